// File: rtl/adma_as_chn_arb.sv
// Weighted round-robin channel arbiter for the shared AXI fetch/split path.
// Holds one grant until the last AXI transaction of the descriptor starts.
module adma_as_chn_arb #(
  parameter int DMA_CHN_NUM   = 4,
  parameter int DMA_CHN_ARB_W = 3,
  parameter int DMA_LENGTH_W  = 16,
  parameter int SRC_ADDR_W    = 32,
  parameter int DST_ADDR_W    = 32,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DMA_CHN_NUM-1:0]               chn_en,
  input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0] chn_arb_rate,
  input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0]    chn_src_addr,
  input  logic [DMA_CHN_NUM*DST_ADDR_W-1:0]    chn_dst_addr,
  input  logic [DMA_CHN_NUM*DMA_LENGTH_W-1:0]  chn_len,
  input  logic [DMA_CHN_NUM-1:0]               chn_vld,
  output logic [DMA_CHN_NUM-1:0]               chn_rdy,
  output logic [DMA_CHN_NUM-1:0]               chn_done,
  output logic [SRC_ADDR_W-1:0]                tx_src_addr,
  output logic [DST_ADDR_W-1:0]                tx_dst_addr,
  output logic [DMA_LENGTH_W-1:0]              tx_len,
  output logic [DMA_CHN_NUM_W-1:0]             tx_chn_id,
  output logic                                 tx_vld,
  input  logic                                 tx_rdy,
  input  logic                                 atx_start,
  input  logic                                 atx_start_last,
  output logic                                 busy
);

  typedef enum logic [1:0] {
    S_IDLE, S_GRANT, S_BUSY, S_ZDONE
  } st_t;

  st_t                      r_state;
  st_t                      w_nxt;
  logic [DMA_CHN_NUM_W-1:0] r_ptr;
  logic [DMA_CHN_NUM_W-1:0] r_gnt_id;
  logic [DMA_CHN_ARB_W-1:0] r_credit;
  logic [SRC_ADDR_W-1:0]    r_src;
  logic [DST_ADDR_W-1:0]    r_dst;
  logic [DMA_LENGTH_W-1:0]  r_len;

  logic [DMA_CHN_NUM-1:0]   w_req;
  logic [DMA_CHN_NUM_W-1:0] w_sel;
  logic                     w_hit;
  logic                     w_reload;
  logic [DMA_CHN_ARB_W-1:0] w_rate;
  logic [DMA_CHN_ARB_W-1:0] w_eff;
  logic [DMA_LENGTH_W-1:0]  w_sel_len;
  logic                     w_fire;
  logic                     w_last;
  logic                     w_dec;

  assign w_req  = chn_vld & chn_en;
  assign w_last = atx_start & atx_start_last;

  // Keep the current channel while it has credit, else rotate from ptr+1.
  always_comb begin
    int idx;
    idx      = 0;
    w_hit    = 1'b0;
    w_reload = 1'b0;
    w_sel    = r_ptr;
    if (w_req[r_ptr] && (r_credit != '0)) begin
      w_hit = 1'b1;
    end else begin
      for (int k = 1; k <= DMA_CHN_NUM; k++) begin
        idx = (int'(r_ptr) + k) % DMA_CHN_NUM;
        if (!w_hit && w_req[idx]) begin
          w_hit    = 1'b1;
          w_reload = 1'b1;
          w_sel    = DMA_CHN_NUM_W'(idx);
        end
      end
    end
  end

  assign w_rate =
    chn_arb_rate[int'(w_sel)*DMA_CHN_ARB_W +: DMA_CHN_ARB_W];
  assign w_eff  =
    (w_rate == '0) ? DMA_CHN_ARB_W'(1) : w_rate;
  assign w_sel_len =
    chn_len[int'(w_sel)*DMA_LENGTH_W +: DMA_LENGTH_W];
  assign w_fire = (r_state == S_IDLE) && w_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_hit)
                 w_nxt = (w_sel_len != '0) ? S_GRANT : S_ZDONE;
      S_GRANT: if (tx_rdy) w_nxt = S_BUSY;
      S_BUSY:  if (w_last) w_nxt = S_IDLE;
      S_ZDONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    chn_rdy  = '0;
    chn_done = '0;
    tx_vld   = 1'b0;
    w_dec    = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_IDLE:  if (w_hit) chn_rdy[w_sel] = 1'b1;
        S_GRANT: tx_vld = 1'b1;
        S_BUSY:  if (w_last) begin
                   chn_done[r_gnt_id] = 1'b1;
                   w_dec              = 1'b1;
                 end
        S_ZDONE: begin
                   chn_done[r_gnt_id] = 1'b1;
                   w_dec              = 1'b1;
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_credit <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
    end else begin
      if (w_fire) begin
        r_ptr    <= w_sel;
        r_gnt_id <= w_sel;
        r_src    <=
          chn_src_addr[int'(w_sel)*SRC_ADDR_W +: SRC_ADDR_W];
        r_dst    <=
          chn_dst_addr[int'(w_sel)*DST_ADDR_W +: DST_ADDR_W];
        r_len    <= w_sel_len;
        if (w_reload) r_credit <= w_eff;
      end else if (w_dec) begin
        r_credit <= r_credit - DMA_CHN_ARB_W'(1);
      end
    end
  end

  assign tx_src_addr = r_src;
  assign tx_dst_addr = r_dst;
  assign tx_len      = r_len;
  assign tx_chn_id   = r_gnt_id;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_adma_as_chn_arb.sv
// Directed self-checking bench for adma_as_chn_arb.
// Each task drives one scenario and checks its own expectations.
module tb_adma_as_chn_arb;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int LW = 16;
  localparam int SW = 32;
  localparam int DW = 32;
  localparam int NW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    chn_en;
  logic [N*AW-1:0] chn_arb_rate;
  logic [N*SW-1:0] chn_src_addr;
  logic [N*DW-1:0] chn_dst_addr;
  logic [N*LW-1:0] chn_len;
  logic [N-1:0]    chn_vld;
  logic [N-1:0]    chn_rdy;
  logic [N-1:0]    chn_done;
  logic [SW-1:0]   tx_src_addr;
  logic [DW-1:0]   tx_dst_addr;
  logic [LW-1:0]   tx_len;
  logic [NW-1:0]   tx_chn_id;
  logic            tx_vld;
  logic            tx_rdy;
  logic            atx_start;
  logic            atx_start_last;
  logic            busy;

  int n_cmp;
  int n_err;

  adma_as_chn_arb #(
    .DMA_CHN_NUM  (N),
    .DMA_CHN_ARB_W(AW),
    .DMA_LENGTH_W (LW),
    .SRC_ADDR_W   (SW),
    .DST_ADDR_W   (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .chn_en        (chn_en),
    .chn_arb_rate  (chn_arb_rate),
    .chn_src_addr  (chn_src_addr),
    .chn_dst_addr  (chn_dst_addr),
    .chn_len       (chn_len),
    .chn_vld       (chn_vld),
    .chn_rdy       (chn_rdy),
    .chn_done      (chn_done),
    .tx_src_addr   (tx_src_addr),
    .tx_dst_addr   (tx_dst_addr),
    .tx_len        (tx_len),
    .tx_chn_id     (tx_chn_id),
    .tx_vld        (tx_vld),
    .tx_rdy        (tx_rdy),
    .atx_start     (atx_start),
    .atx_start_last(atx_start_last),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int ch, input logic [SW-1:0] s,
                          input logic [DW-1:0] d,
                          input logic [LW-1:0] l,
                          input logic [AW-1:0] r);
    chn_src_addr[ch*SW +: SW] = s;
    chn_dst_addr[ch*DW +: DW] = d;
    chn_len[ch*LW +: LW]      = l;
    chn_arb_rate[ch*AW +: AW] = r;
  endtask

  task automatic clear_inputs;
    chn_en         = '0;
    chn_vld        = '0;
    chn_arb_rate   = '0;
    chn_src_addr   = '0;
    chn_dst_addr   = '0;
    chn_len        = '0;
    tx_rdy         = 1'b1;
    atx_start      = 1'b0;
    atx_start_last = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Bounded wait for a chn_rdy pulse; returns 0 on timeout.
  task automatic wait_rdy(output logic [N-1:0] got);
    got = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (chn_rdy != '0) begin
        got = chn_rdy;
        break;
      end
      tick();
    end
  endtask

  // From the grant cycle: accept, 3 BUSY cycles, then last start.
  task automatic do_txn(input logic [N-1:0] vld_after,
                        output logic [N-1:0] done);
    tick();
    chn_vld = vld_after;
    tick();
    tick();
    tick();
    atx_start      = 1'b1;
    atx_start_last = 1'b1;
    #1;
    done = chn_done;
    tick();
    atx_start      = 1'b0;
    atx_start_last = 1'b0;
  endtask

  task automatic test_reset;
    logic [N-1:0] got;
    clear_inputs();
    chn_en  = 4'b0001;
    chn_vld = 4'b1111;
    for (int c = 0; c < N; c++)
      set_desc(c, 32'h100 * c, 32'h200 * c, 16'h40, 3'd1);
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++;
    if (chn_rdy !== 4'b0) begin
      n_err++;
      $display("FAIL rst_rdy got %b exp 0000", chn_rdy);
    end
    n_cmp++;
    if (chn_done !== 4'b0) begin
      n_err++;
      $display("FAIL rst_done got %b exp 0000", chn_done);
    end
    n_cmp++;
    if ({tx_vld, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_vld_busy got %b%b exp 00",
               tx_vld, busy);
    end
    n_cmp++;
    if ({tx_src_addr, tx_dst_addr, tx_len, tx_chn_id} !== '0) begin
      n_err++;
      $display("FAIL rst_tx got %h %h %h %h exp 0",
               tx_src_addr, tx_dst_addr, tx_len, tx_chn_id);
    end
    rst_n = 1'b1;
    wait_rdy(got);
    n_cmp++;
    if (got !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_first_gnt got %b exp 0001", got);
    end
    tick();
    #1;
    n_cmp++;
    if (tx_vld !== 1'b1) begin
      n_err++;
      $display("FAIL rst_txvld_lat got %b exp 1", tx_vld);
    end
    n_cmp++;
    if ({tx_chn_id, tx_len} !== {2'd0, 16'h40}) begin
      n_err++;
      $display("FAIL rst_tx_desc got %h %h exp 0 0040",
               tx_chn_id, tx_len);
    end
  endtask

  task automatic test_weight;
    logic [N-1:0] got;
    logic [N-1:0] done;
    logic [N-1:0] exp;
    int seq [6] = '{0, 0, 1, 0, 0, 1};
    clear_inputs();
    chn_en = 4'b0011;
    set_desc(0, 32'hA000, 32'hB000, 16'h40, 3'd2);
    set_desc(1, 32'hA100, 32'hB100, 16'h40, 3'd1);
    apply_reset();
    chn_vld = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      exp = 4'(1 << seq[i]);
      wait_rdy(got);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL wrr_gnt[%0d] got %b exp %b", i, got, exp);
      end
      do_txn(4'b0011, done);
      n_cmp++;
      if (done !== exp) begin
        n_err++;
        $display("FAIL wrr_done[%0d] got %b exp %b", i, done, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [N-1:0] got;
    clear_inputs();
    chn_en  = 4'b0001;
    chn_vld = 4'b0001;
    tx_rdy  = 1'b0;
    set_desc(0, 32'h1000, 32'h2000, 16'h10, 3'd1);
    apply_reset();
    wait_rdy(got);
    n_cmp++;
    if (got !== 4'b0001) begin
      n_err++;
      $display("FAIL bp_gnt got %b exp 0001", got);
    end
    tick();
    set_desc(0, 32'hDEAD, 32'hBEEF, 16'h77, 3'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (tx_vld !== 1'b1) begin
        n_err++;
        $display("FAIL bp_vld[%0d] got %b exp 1", i, tx_vld);
      end
      n_cmp++;
      if (tx_src_addr !== 32'h1000) begin
        n_err++;
        $display("FAIL bp_src[%0d] got %h exp 1000",
                 i, tx_src_addr);
      end
      n_cmp++;
      if (tx_dst_addr !== 32'h2000) begin
        n_err++;
        $display("FAIL bp_dst[%0d] got %h exp 2000",
                 i, tx_dst_addr);
      end
      n_cmp++;
      if (tx_len !== 16'h10) begin
        n_err++;
        $display("FAIL bp_len[%0d] got %h exp 0010", i, tx_len);
      end
      n_cmp++;
      if (chn_rdy !== 4'b0) begin
        n_err++;
        $display("FAIL bp_rdy[%0d] got %b exp 0000", i, chn_rdy);
      end
      if (i < 4) tick();
    end
    tx_rdy = 1'b1;
    tick();
    #1;
    n_cmp++;
    if ({tx_vld, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_busy got vld=%b busy=%b exp vld=0 busy=1",
               tx_vld, busy);
    end
  endtask

  task automatic test_zero_len;
    logic [N-1:0] got;
    clear_inputs();
    chn_en  = 4'b0101;
    chn_vld = 4'b0110;
    set_desc(1, 32'h11, 32'h22, 16'h40, 3'd1);
    set_desc(2, 32'h33, 32'h44, 16'h00, 3'd1);
    apply_reset();
    wait_rdy(got);
    n_cmp++;
    if (got !== 4'b0100) begin
      n_err++;
      $display("FAIL zl_gnt got %b exp 0100", got);
    end
    tick();
    #1;
    n_cmp++;
    if (chn_done !== 4'b0100) begin
      n_err++;
      $display("FAIL zl_done got %b exp 0100", chn_done);
    end
    n_cmp++;
    if ({tx_vld, chn_rdy} !== 5'b0) begin
      n_err++;
      $display("FAIL zl_novld got vld=%b rdy=%b exp 0 0000",
               tx_vld, chn_rdy);
    end
    chn_vld = 4'b0010;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({chn_rdy, chn_done, tx_vld} !== 9'b0) begin
        n_err++;
        $display("FAIL zl_idle[%0d] got rdy=%b done=%b vld=%b exp 0",
                 i, chn_rdy, chn_done, tx_vld);
      end
      tick();
    end
  endtask

  task automatic test_non_last;
    logic [N-1:0] got;
    clear_inputs();
    chn_en  = 4'b0001;
    chn_vld = 4'b0001;
    set_desc(0, 32'h500, 32'h600, 16'h40, 3'd1);
    apply_reset();
    wait_rdy(got);
    n_cmp++;
    if (got !== 4'b0001) begin
      n_err++;
      $display("FAIL nl_gnt got %b exp 0001", got);
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      atx_start      = 1'b1;
      atx_start_last = 1'b0;
      #1;
      n_cmp++;
      if ({chn_done, busy} !== 5'b00001) begin
        n_err++;
        $display("FAIL nl_early[%0d] got done=%b busy=%b exp 0 1",
                 i, chn_done, busy);
      end
      tick();
    end
    atx_start_last = 1'b1;
    #1;
    n_cmp++;
    if (chn_done !== 4'b0001) begin
      n_err++;
      $display("FAIL nl_done got %b exp 0001", chn_done);
    end
    chn_vld = 4'b0000;
    tick();
    atx_start      = 1'b0;
    atx_start_last = 1'b0;
    #1;
    n_cmp++;
    if ({chn_done, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL nl_after got done=%b busy=%b exp 0 0",
               chn_done, busy);
    end
  endtask

  task automatic test_reset_busy;
    logic [N-1:0] got;
    clear_inputs();
    chn_en  = 4'b1000;
    chn_vld = 4'b1000;
    set_desc(1, 32'h710, 32'h720, 16'h40, 3'd1);
    set_desc(3, 32'h730, 32'h740, 16'h40, 3'd2);
    apply_reset();
    wait_rdy(got);
    n_cmp++;
    if (got !== 4'b1000) begin
      n_err++;
      $display("FAIL rb_gnt got %b exp 1000", got);
    end
    tick();
    tick();
    #1;
    n_cmp++;
    if ({busy, tx_chn_id} !== {1'b1, 2'd3}) begin
      n_err++;
      $display("FAIL rb_busy got busy=%b id=%0d exp 1 3",
               busy, tx_chn_id);
    end
    rst_n = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({busy, tx_vld, chn_done, tx_chn_id} !== 8'b0) begin
      n_err++;
      $display("FAIL rb_rst got busy=%b vld=%b done=%b id=%0d exp 0",
               busy, tx_vld, chn_done, tx_chn_id);
    end
    atx_start      = 1'b1;
    atx_start_last = 1'b1;
    #1;
    n_cmp++;
    if (chn_done !== 4'b0) begin
      n_err++;
      $display("FAIL rb_nodone got %b exp 0000", chn_done);
    end
    atx_start      = 1'b0;
    atx_start_last = 1'b0;
    chn_en  = 4'b1010;
    chn_vld = 4'b1010;
    rst_n   = 1'b1;
    wait_rdy(got);
    n_cmp++;
    if (got !== 4'b0010) begin
      n_err++;
      $display("FAIL rb_ptr0 got %b exp 0010", got);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_weight();
    test_backpressure();
    test_zero_len();
    test_non_last();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adma_as_chn_arb.md
Name: adma_as_chn_arb

Overview:
Weighted round-robin scheduler that shares the single AXI-transaction fetch/split datapath between DMA_CHN_NUM channel descriptor queues. It selects one channel and registers that channel's descriptor onto the tx_* handshake feeding the fetch block. It then locks the grant until the fetch block reports the last AXI transaction of that DMA transaction started, and pulses a per-channel completion.

Parameters:
DMA_CHN_NUM, 4, number of requesting channels (≥2)
DMA_CHN_ARB_W, 3, width of per-channel arbitration weight
DMA_LENGTH_W, 16, descriptor length width
SRC_ADDR_W, 32, source address width
DST_ADDR_W, 32, destination address width
DMA_CHN_NUM_W, $clog2(DMA_CHN_NUM), derived; do not override

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
chn_en  in  DMA_CHN_NUM  per-channel enable
chn_arb_rate  in  DMA_CHN_NUM*DMA_CHN_ARB_W  per-channel weight, channel i at [i*W +: W]
chn_src_addr  in  DMA_CHN_NUM*SRC_ADDR_W  per-channel source address, flattened
chn_dst_addr  in  DMA_CHN_NUM*DST_ADDR_W  per-channel destination address, flattened
chn_len  in  DMA_CHN_NUM*DMA_LENGTH_W  per-channel length, flattened
chn_vld  in  DMA_CHN_NUM  descriptor valid per channel
chn_rdy  out  DMA_CHN_NUM  descriptor accept, one-hot or zero
chn_done  out  DMA_CHN_NUM  one-cycle completion pulse, one-hot or zero
tx_src_addr  out  SRC_ADDR_W  to fetch block
tx_dst_addr  out  DST_ADDR_W  to fetch block
tx_len  out  DMA_LENGTH_W  to fetch block
tx_chn_id  out  DMA_CHN_NUM_W  granted channel index
tx_vld  out  1  descriptor valid to fetch block
tx_rdy  in  1  fetch block accept
atx_start  in  1  an AXI transaction started
atx_start_last  in  1  qualifies atx_start as the last of the DMA transaction
busy  out  1  state != IDLE

Behaviour:
- Registers: state {IDLE, GRANT, BUSY, ZDONE}, ptr (DMA_CHN_NUM_W), credit (DMA_CHN_ARB_W), gnt_id, tx_* holding registers.
- Reset (rst_n=0 at a clk edge, from any state, including mid-BUSY): state=IDLE, ptr=0, credit=0, gnt_id=0, tx_*=0, tx_vld=0, chn_rdy=0, chn_done=0, busy=0. An in-flight fetch is not cancelled by this block.
- req[i] = chn_vld[i] & chn_en[i]. eff_w[i] = chn_arb_rate[i], with 0 treated as 1.
- IDLE selection is combinational in the IDLE cycle:
  - If req[ptr] and credit != 0: sel = ptr, credit unchanged.
  - Otherwise search ptr+1, ptr+2, … (modulo DMA_CHN_NUM) ending with ptr itself. sel = first requester found; ptr <= sel; credit <= eff_w[sel].
  - If there is no requester, stay in IDLE with chn_rdy = 0.
- On a selection in IDLE:
  - chn_rdy[sel] = 1 for exactly that cycle. The descriptor is captured into tx_* and gnt_id/tx_chn_id <= sel.
  - If chn_len of sel != 0, go to GRANT. If it is 0, go to ZDONE and do not forward it.
- GRANT: tx_vld = 1. tx_* are stable until tx_rdy. On tx_vld & tx_rdy, go to BUSY and drop tx_vld the next cycle. Minimum IDLE→tx_vld latency is 1 cycle.
- BUSY: wait for atx_start & atx_start_last. When seen:
  - chn_done[gnt_id] = 1 for that one cycle (combinational from state), and credit <= credit-1.
  - Go to IDLE.
  - atx_start without last is ignored.
- ZDONE: chn_done[gnt_id] = 1 for one cycle, credit <= credit-1, go to IDLE.
- atx_start/atx_start_last are ignored in IDLE and GRANT. The fetch block registers its input, so atx_start never coincides with the tx handshake.
- Credit exhausted (0) forces rotation on the next IDLE search. If ptr is the sole requester, it is reselected last in the search order and credit is reloaded.
- chn_en deasserting while granted does not abort the grant; it only affects future selection. chn_arb_rate is sampled only at reload.
- Throughput: at most one DMA transaction in flight. Back-to-back grants are separated by ≥1 IDLE cycle.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with all chn_vld=1 → all outputs 0; the first grant after release goes to channel 0 and tx_vld rises 1 cycle after chn_rdy[0].
- Weight ratio: chn0 rate=2, chn1 rate=1, both always valid, len=0x40; complete each via atx_start & atx_start_last after 3 cycles → grant sequence 0,0,1,0,0,1; chn_done order matches.
- Backpressure: tx_rdy=0 for 5 cycles in GRANT with src=0x1000, dst=0x2000, len=0x10 → tx_vld held at 1, outputs stable, no chn_rdy pulse; then tx_rdy=1 → BUSY and tx_vld=0.
- Zero-length and disabled channel: chn2 len=0 with en=1, chn1 en=0 but valid, ptr=0, chn0 idle → chn_rdy[2] pulses, tx_vld never asserts, chn_done[2] pulses the next cycle, chn1 never gets chn_rdy.
- Non-last starts: in BUSY, drive atx_start=1, atx_start_last=0 three times, then 1/1 → chn_done only on the fourth pulse.
- Reset mid-BUSY: rst_n=0 while granted to chn3 → next cycle state IDLE, busy=0, ptr=0, no chn_done[3].
